// File: rtl/fifo_3w_arb_pkg.sv
// fifo_3w_arb_pkg: FSM state codes, lane count and clogb2 shared by the fifo_3w_arb slice
package fifo_3w_arb_pkg;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int NUM_LANES = 3;
  function automatic int clogb2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fifo_3w_arb_rr_pick3.sv
// rr_pick3: picks up to max_grant set bits of mask in circular order from rr_ptr, packed onto lanes
module rr_pick3
  import fifo_3w_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clogb2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]              mask,
  input  logic [IW-1:0]                   rr_ptr,
  input  logic [1:0]                      max_grant,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_LANES-1:0][IW-1:0]    lane_idx,
  output logic [NUM_LANES-1:0]            lane_val,
  output logic [1:0]                      n_grant
);
  // circular scan; the k-th hit lands on lane k so scan order becomes FIFO order
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    lane_idx = '0;
    lane_val = '0;
    n_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (mask[j] && n_grant < max_grant) begin
        grant[j] = 1'b1;
        lane_idx[n_grant] = IW'(j);
        lane_val[n_grant] = 1'b1;
        n_grant = n_grant + 2'd1;
      end
    end
  end
endmodule

// File: rtl/fifo_3w_arb.sv
// fifo_3w_arb: round-robin scheduler packing up to 3 grants/cycle onto fifo_3w write lanes (option: FIFO_3W_ARB_STARVE_EN)
module fifo_3w_arb
  import fifo_3w_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FIFO_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_WIDTH    = clogb2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [CNT_WIDTH-1:0]          fifo_size,
  output logic                          w_val_0,
  output logic                          w_val_1,
  output logic                          w_val_2,
  output logic [FIFO_WIDTH-1:0]         w_data_0,
  output logic [FIFO_WIDTH-1:0]         w_data_1,
  output logic [FIFO_WIDTH-1:0]         w_data_2,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy
);
  localparam int IW = clogb2(NUM_REQ);
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, scan_last;
  logic [CNT_WIDTH:0] inflight, free_raw;
  logic [IW:0] n_req;
  logic [1:0] max_grant;
  logic [NUM_LANES-1:0][IW-1:0] lane_idx, s_idx;
  logic [NUM_LANES-1:0] lane_val, s_val;
  // space check: in-flight lanes are counted so a lagging fifo_size never overcommits
  always_comb begin
    logic [1:0] m;
    inflight = (CNT_WIDTH+1)'(w_val_0) + (CNT_WIDTH+1)'(w_val_1) + (CNT_WIDTH+1)'(w_val_2);
    free_raw = (CNT_WIDTH+1)'(FIFO_DEPTH - 1) - {1'b0, fifo_size} - inflight;
    n_req = '0;
    for (int i = 0; i < NUM_REQ; i++) n_req = n_req + (IW+1)'(req_val[i]);
    m = free_raw[CNT_WIDTH] ? 2'd0 : (free_raw > (CNT_WIDTH+1)'(3)) ? 2'd3 : free_raw[1:0];
    m = (n_req < (IW+1)'(m)) ? n_req[1:0] : m;
    max_grant = (rst_n && en && state == ST_RUN && !flush_req) ? m : 2'd0;
  end
`ifdef FIFO_3W_ARB_STARVE_EN
  localparam int SW = clogb2(STARVE_LIMIT + 1);
  logic [NUM_REQ-1:0][SW-1:0] wait_cnt;
  logic [NUM_REQ-1:0] urgent, u_grant, s_grant;
  logic [NUM_LANES-1:0][IW-1:0] u_idx;
  logic [NUM_LANES-1:0] u_val;
  logic [1:0] u_n, unused_s_n;
  // requesters that waited STARVE_LIMIT cycles jump the queue
  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_REQ; i++) urgent[i] = req_val[i] && wait_cnt[i] == SW'(STARVE_LIMIT);
  end
  rr_pick3 #(.NUM_REQ(NUM_REQ), .IW(IW)) u_urg (
    .mask(urgent), .rr_ptr('0), .max_grant(max_grant),
    .grant(u_grant), .lane_idx(u_idx), .lane_val(u_val), .n_grant(u_n)
  );
  rr_pick3 #(.NUM_REQ(NUM_REQ), .IW(IW)) u_scan (
    .mask(req_val & ~u_grant), .rr_ptr(rr_ptr), .max_grant(max_grant - u_n),
    .grant(s_grant), .lane_idx(s_idx), .lane_val(s_val), .n_grant(unused_s_n)
  );
  assign req_rdy = u_grant | s_grant;
  // urgent grants take the lowest lanes, scan grants follow
  always_comb begin
    lane_idx = '0;
    lane_val = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k < int'(u_n)) begin
        lane_idx[k] = u_idx[k];
        lane_val[k] = u_val[k];
      end else begin
        lane_idx[k] = s_idx[k - int'(u_n)];
        lane_val[k] = s_val[k - int'(u_n)];
      end
    end
  end
  // saturating wait counters, cleared on grant or when the requester idles
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      wait_cnt[i] <= (!rst_n || !req_val[i] || req_rdy[i]) ? '0 :
                     (wait_cnt[i] == SW'(STARVE_LIMIT)) ? wait_cnt[i] : wait_cnt[i] + SW'(1);
  end
`else
  logic [1:0] unused_n;
  logic [7:0] unused_starve;
  assign unused_starve = 8'(STARVE_LIMIT);
  rr_pick3 #(.NUM_REQ(NUM_REQ), .IW(IW)) u_scan (
    .mask(req_val), .rr_ptr(rr_ptr), .max_grant(max_grant),
    .grant(req_rdy), .lane_idx(s_idx), .lane_val(s_val), .n_grant(unused_n)
  );
  assign lane_idx = s_idx;
  assign lane_val = s_val;
`endif
  // last requester granted by the scan seeds the next pointer
  always_comb begin
    scan_last = rr_ptr;
    for (int k = 0; k < NUM_LANES; k++) if (s_val[k]) scan_last = s_idx[k];
  end
  // pointer advances past the last scan grant, holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= '0;
    else if (s_val[0]) rr_ptr <= (scan_last == IW'(NUM_REQ - 1)) ? '0 : scan_last + IW'(1);
  end
  // lane registers; idle lanes keep their last data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {w_val_2, w_val_1, w_val_0} <= '0;
      w_data_0 <= '0;
      w_data_1 <= '0;
      w_data_2 <= '0;
    end else begin
      {w_val_2, w_val_1, w_val_0} <= lane_val;
      if (lane_val[0]) w_data_0 <= req_data[lane_idx[0]*FIFO_WIDTH +: FIFO_WIDTH];
      if (lane_val[1]) w_data_1 <= req_data[lane_idx[1]*FIFO_WIDTH +: FIFO_WIDTH];
      if (lane_val[2]) w_data_2 <= req_data[lane_idx[2]*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end
  // flush sequence: stop granting, wait for lanes and FIFO to empty, pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else if (state == ST_RUN) state <= flush_req ? ST_DRAIN : ST_RUN;
    else if (state == ST_DRAIN) state <= (inflight == '0 && fifo_size == '0) ? ST_DONE : ST_DRAIN;
    else state <= ST_RUN;
  end
  assign flush_done = state == ST_DONE;
  assign busy = state != ST_RUN;
endmodule
